// File: rtl/ctrl_bus_arbiter_if.sv
// Control-bus arbiter interface: per-master request/bus slices in,
// grant status and the muxed engine-side bus out.
interface ctrl_bus_arbiter_if #(
  parameter int MASTERS = 3,
  parameter int ADR_W   = 7,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 5
);
  localparam int OW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  // master side
  logic [MASTERS-1:0]        req;
  logic [MASTERS*ADR_W-1:0]  m_adr;
  logic [MASTERS*SEL_W-1:0]  m_sel;
  logic [MASTERS-1:0]        m_read;
  logic [MASTERS-1:0]        m_write;
  logic [MASTERS*DATA_W-1:0] m_wdata;
  logic [MASTERS-1:0]        m_patch_send;
  logic [DATA_W-1:0]         rdata_in;

  // arbiter status
  logic [MASTERS-1:0]        gnt;
  logic [OW-1:0]             owner;
  logic                      act;
  logic                      tenure_err;

  // engine side
  logic [ADR_W-1:0]          adr;
  logic [SEL_W-1:0]          sel;
  logic                      read;
  logic                      write;
  logic [DATA_W-1:0]         wdata;
  logic                      patch_send;
  logic [DATA_W-1:0]         rdata;

  modport master (
    output req, m_adr, m_sel, m_read, m_write, m_wdata, m_patch_send, rdata_in,
    input  gnt, owner, act, tenure_err, adr, sel, read, write, wdata,
           patch_send, rdata
  );

  modport slave (
    input  req, m_adr, m_sel, m_read, m_write, m_wdata, m_patch_send, rdata_in,
    output gnt, owner, act, tenure_err, adr, sel, read, write, wdata,
           patch_send, rdata
  );
endinterface

// File: rtl/ctrl_bus_arbiter.sv
// N-master arbiter for the synth_engine control bus (CLOCK_25 domain).
// Fixed-priority or round-robin selection, grant handshake, post-request
// hold-off and optional tenure limiting with forced preemption.
module ctrl_bus_arbiter #(
  parameter int MASTERS    = 3,
  parameter int ADR_W      = 7,
  parameter int DATA_W     = 8,
  parameter int SEL_W      = 5,
  parameter int HOLD_CYC   = 5,
  parameter int DEFAULT_M  = 1,
  parameter int PRIO_MODE  = 0,
  parameter int MAX_TENURE = 0
) (
  input logic               CLOCK_25,
  input logic               reset_reg,
  ctrl_bus_arbiter_if.slave bus
);

  localparam int OW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam int TW = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
  localparam int unsigned NM = MASTERS;
  localparam logic [OW-1:0] DEF = OW'(DEFAULT_M);

  typedef enum logic [1:0] {IDLE, OWN, HOLD} state_t;

  state_t             state;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      rr_ptr;
  logic [MASTERS-1:0] gnt_q;
  logic               act_q;
  logic               tenure_err_q;
  logic               forced_q;
  logic [HW-1:0]      hold_cnt;
  logic [TW-1:0]      ten_cnt;

  logic [MASTERS-1:0] own_mask;
  logic [MASTERS-1:0] others;
  logic               others_pend;
  logic               req_own;
  logic               ten_limit;
  logic               preempt;
  logic               leave_own;
  logic               expire;
  logic [MASTERS-1:0] exp_req;
  logic [OW-1:0]      next_rr;
  logic [OW-1:0]      exp_win;
  logic [OW-1:0]      idle_win;

  function automatic logic [MASTERS-1:0] onehot(input logic [OW-1:0] i);
    logic [MASTERS-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  // Fixed priority scans from index 0; round-robin scans from ptr, wrapping.
  function automatic logic [OW-1:0] pick(input logic [MASTERS-1:0] r,
                                         input logic [OW-1:0]      ptr);
    logic [OW-1:0] w;
    logic          found;
    int unsigned   idx;
    w     = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NM; k++) begin
      if (PRIO_MODE == 0) idx = k;
      else                idx = (32'(ptr) + k) % NM;
      if (!found && r[OW'(idx)]) begin
        w     = OW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Arbitration decisions: tenure limit, hold expiry and the next winner.
  always_comb begin
    own_mask    = onehot(owner_q);
    others      = bus.req & ~own_mask;
    others_pend = |others;
    req_own     = bus.req[owner_q];
    ten_limit   = (MAX_TENURE > 0) && others_pend &&
                  (ten_cnt == TW'(MAX_TENURE - 1));
    preempt     = (state == OWN) ? ten_limit : forced_q;
    leave_own   = ten_limit || !req_own;
    // Expiry is reached either straight from OWN (no hold configured) or at
    // the end of HOLD; both paths share the same handover logic below.
    expire      = ((state == OWN) && leave_own && (HOLD_CYC == 0)) ||
                  ((state == HOLD) && !(req_own && !forced_q) &&
                   (hold_cnt == '0));
    exp_req     = preempt ? others : bus.req;
    next_rr     = (owner_q == OW'(MASTERS - 1)) ? '0 : owner_q + 1'b1;
    exp_win     = pick(exp_req, next_rr);
    idle_win    = pick(bus.req, rr_ptr);
  end

  // Arbiter FSM with registered grant, owner, activity and tenure-error outputs.
  always_ff @(posedge CLOCK_25 or posedge reset_reg) begin
    if (reset_reg) begin
      state        <= IDLE;
      owner_q      <= DEF;
      gnt_q        <= '0;
      act_q        <= 1'b0;
      tenure_err_q <= 1'b0;
      forced_q     <= 1'b0;
      hold_cnt     <= '0;
      ten_cnt      <= '0;
      rr_ptr       <= DEF;
    end else begin
      tenure_err_q <= (state == OWN) && ten_limit;
      if (expire) begin
        rr_ptr   <= next_rr;
        forced_q <= 1'b0;
        ten_cnt  <= '0;
        hold_cnt <= '0;
        if (|exp_req) begin
          state   <= OWN;
          owner_q <= exp_win;
          gnt_q   <= onehot(exp_win);
          act_q   <= 1'b1;
        end else begin
          state   <= IDLE;
          owner_q <= DEF;
          gnt_q   <= '0;
          act_q   <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (|bus.req) begin
              state    <= OWN;
              owner_q  <= idle_win;
              gnt_q    <= onehot(idle_win);
              act_q    <= 1'b1;
              ten_cnt  <= '0;
              forced_q <= 1'b0;
            end
          end
          OWN: begin
            if (leave_own) begin
              state    <= HOLD;
              hold_cnt <= HW'(HOLD_CYC - 1);
              forced_q <= ten_limit;
              ten_cnt  <= '0;
            end else if (others_pend) begin
              ten_cnt <= ten_cnt + 1'b1;
            end else begin
              ten_cnt <= '0;
            end
          end
          HOLD: begin
            if (req_own && !forced_q) begin
              state   <= OWN;
              ten_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            owner_q <= DEF;
            gnt_q   <= '0;
            act_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.owner      = owner_q;
  assign bus.act        = act_q;
  assign bus.tenure_err = tenure_err_q;
  assign bus.rdata      = bus.rdata_in;

  // Bus mux from the owner register; strobes are blocked while in reset.
  always_comb begin
    bus.adr        = bus.m_adr[int'(owner_q) * ADR_W +: ADR_W];
    bus.sel        = bus.m_sel[int'(owner_q) * SEL_W +: SEL_W];
    bus.wdata      = bus.m_wdata[int'(owner_q) * DATA_W +: DATA_W];
    bus.read       = bus.m_read[owner_q] & ~reset_reg;
    bus.write      = bus.m_write[owner_q] & ~reset_reg;
    bus.patch_send = bus.m_patch_send[owner_q] & ~reset_reg;
  end

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// Bench for ctrl_bus_arbiter: DUT A (fixed priority, hold 5) and
// DUT B (round-robin, no hold, tenure limit 4), scoreboard-checked.
module tb_ctrl_bus_arbiter;

  logic CLOCK_25;
  logic rst;

  ctrl_bus_arbiter_if #(.MASTERS(3), .ADR_W(7), .DATA_W(8), .SEL_W(5)) ifa ();
  ctrl_bus_arbiter_if #(.MASTERS(3), .ADR_W(7), .DATA_W(8), .SEL_W(5)) ifb ();

  ctrl_bus_arbiter #(
    .MASTERS(3), .ADR_W(7), .DATA_W(8), .SEL_W(5),
    .HOLD_CYC(5), .DEFAULT_M(1), .PRIO_MODE(0), .MAX_TENURE(0)
  ) u_a (
    .CLOCK_25 (CLOCK_25),
    .reset_reg(rst),
    .bus      (ifa)
  );

  ctrl_bus_arbiter #(
    .MASTERS(3), .ADR_W(7), .DATA_W(8), .SEL_W(5),
    .HOLD_CYC(0), .DEFAULT_M(1), .PRIO_MODE(1), .MAX_TENURE(4)
  ) u_b (
    .CLOCK_25 (CLOCK_25),
    .reset_reg(rst),
    .bus      (ifb)
  );

  initial CLOCK_25 = 1'b0;
  always #20 CLOCK_25 = ~CLOCK_25;

  logic [6:0] ADR [3];
  logic [4:0] SEL [3];
  logic [7:0] WD  [3];
  logic [2:0] PS;

  typedef struct {
    string      name;
    logic [2:0] req;
    logic [2:0] wr;
    logic [2:0] gnt;
    int         own;
    logic       act;
    logic       write;
    logic       te;
  } vec_t;

  typedef struct {
    string      name;
    bit         d;
    logic [2:0] gnt;
    int         own;
    logic       act;
    logic       write;
    logic       ps;
    logic       te;
    logic [6:0] adr;
    logic [4:0] sel;
    logic [7:0] wd;
    logic [7:0] rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(string name, logic [2:0] req, logic [2:0] wr,
                              logic [2:0] gnt, int own, logic act,
                              logic write, logic te);
    vec_t v;
    v.name = name; v.req = req; v.wr = wr; v.gnt = gnt; v.own = own;
    v.act = act; v.write = write; v.te = te;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs on DUT d and queue what it must show this cycle.
  task automatic apply(bit d, logic [2:0] req, logic [2:0] wr, logic [2:0] gnt,
                       int own, logic act, logic write, logic te, bit in_rst,
                       string name);
    exp_t       e;
    logic [7:0] rv;
    rv = 8'($urandom);
    if (!d) begin
      ifa.req = req; ifa.m_write = wr; ifa.rdata_in = rv;
    end else begin
      ifb.req = req; ifb.m_write = wr; ifb.rdata_in = rv;
    end
    e.name = name; e.d = d; e.gnt = gnt; e.own = own; e.act = act;
    e.write = write; e.te = te;
    e.ps  = in_rst ? 1'b0 : PS[own];
    e.adr = ADR[own]; e.sel = SEL[own]; e.wd = WD[own]; e.rd = rv;
    sb.push_back(e);
  endtask

  exp_t       me;
  logic [2:0] g_g;
  int         g_own;
  logic       g_act, g_wr, g_ps, g_te;
  logic [6:0] g_adr;
  logic [4:0] g_sel;
  logic [7:0] g_wd, g_rd;

  // Compare queued expectations against the DUT away from the active edge.
  always @(negedge CLOCK_25) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      if (!me.d) begin
        g_g = ifa.gnt; g_own = int'(ifa.owner); g_act = ifa.act; g_wr = ifa.write;
        g_ps = ifa.patch_send; g_te = ifa.tenure_err; g_adr = ifa.adr;
        g_sel = ifa.sel; g_wd = ifa.wdata; g_rd = ifa.rdata;
      end else begin
        g_g = ifb.gnt; g_own = int'(ifb.owner); g_act = ifb.act; g_wr = ifb.write;
        g_ps = ifb.patch_send; g_te = ifb.tenure_err; g_adr = ifb.adr;
        g_sel = ifb.sel; g_wd = ifb.wdata; g_rd = ifb.rdata;
      end
      n_cmp++;
      if (g_g !== me.gnt || g_own != me.own || g_act !== me.act ||
          g_wr !== me.write || g_ps !== me.ps || g_te !== me.te ||
          g_adr !== me.adr || g_sel !== me.sel || g_wd !== me.wd ||
          g_rd !== me.rd) begin
        n_err++;
        $display("FAIL %s: got gnt=%b own=%0d act=%b wr=%b ps=%b te=%b adr=%h sel=%h wd=%h rd=%h; want gnt=%b own=%0d act=%b wr=%b ps=%b te=%b adr=%h sel=%h wd=%h rd=%h",
                 me.name, g_g, g_own, g_act, g_wr, g_ps, g_te, g_adr, g_sel,
                 g_wd, g_rd, me.gnt, me.own, me.act, me.write, me.ps, me.te,
                 me.adr, me.sel, me.wd, me.rd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    ADR[0] = 7'h10; ADR[1] = 7'h12; ADR[2] = 7'h2A;
    SEL[0] = 5'h01; SEL[1] = 5'h02; SEL[2] = 5'h04;
    WD[0]  = 8'hA1; WD[1]  = 8'hB2; WD[2]  = 8'hC3;
    PS     = 3'b101;

    // name              req     wr      gnt     own act wr te
    add("t1_idle",       3'b000, 3'b000, 3'b000, 1, 0, 0, 0);
    add("t1_dflt_wr",    3'b000, 3'b010, 3'b000, 1, 0, 1, 0);
    add("t1_nonown_wr",  3'b000, 3'b001, 3'b000, 1, 0, 0, 0);
    add("t2_req",        3'b001, 3'b000, 3'b000, 1, 0, 0, 0);
    add("t2_gnt",        3'b001, 3'b000, 3'b001, 0, 1, 0, 0);
    add("t2_own_wr",     3'b001, 3'b001, 3'b001, 0, 1, 1, 0);
    add("t2_own3_m1wr",  3'b000, 3'b010, 3'b001, 0, 1, 0, 0);
    add("t2_hold4",      3'b000, 3'b000, 3'b001, 0, 1, 0, 0);
    add("t2_hold3_wr",   3'b000, 3'b001, 3'b001, 0, 1, 1, 0);
    add("t2_hold2",      3'b000, 3'b000, 3'b001, 0, 1, 0, 0);
    add("t2_hold1",      3'b000, 3'b000, 3'b001, 0, 1, 0, 0);
    add("t2_hold0",      3'b000, 3'b000, 3'b001, 0, 1, 0, 0);
    add("t2_back_idle",  3'b000, 3'b000, 3'b000, 1, 0, 0, 0);
    add("t3_req",        3'b101, 3'b000, 3'b000, 1, 0, 0, 0);
    add("t3_gnt0",       3'b101, 3'b000, 3'b001, 0, 1, 0, 0);
    add("t3_own0",       3'b100, 3'b000, 3'b001, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add("t3_hold0",    3'b100, 3'b000, 3'b001, 0, 1, 0, 0);
    add("t3_handover",   3'b100, 3'b000, 3'b100, 2, 1, 0, 0);
    add("t3_own2",       3'b000, 3'b000, 3'b100, 2, 1, 0, 0);
    add("t5_hold4",      3'b001, 3'b000, 3'b100, 2, 1, 0, 0);
    add("t5_hold3",      3'b001, 3'b000, 3'b100, 2, 1, 0, 0);
    add("t5_hold2_rereq",3'b101, 3'b000, 3'b100, 2, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      add("t5_reown",    3'b101, 3'b000, 3'b100, 2, 1, 0, 0);
    add("t5_drop",       3'b001, 3'b000, 3'b100, 2, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add("t5_hold",     3'b001, 3'b000, 3'b100, 2, 1, 0, 0);
    add("t5_handover",   3'b000, 3'b000, 3'b001, 0, 1, 0, 0);
    add("t5_hold_m0",    3'b000, 3'b000, 3'b001, 0, 1, 0, 0);

    rst = 1'b1;
    ifa.req = '0; ifa.m_read = '0; ifa.m_write = '0; ifa.rdata_in = '0;
    ifb.req = '0; ifb.m_read = '0; ifb.m_write = '0; ifb.rdata_in = '0;
    ifa.m_adr = {ADR[2], ADR[1], ADR[0]}; ifb.m_adr = {ADR[2], ADR[1], ADR[0]};
    ifa.m_sel = {SEL[2], SEL[1], SEL[0]}; ifb.m_sel = {SEL[2], SEL[1], SEL[0]};
    ifa.m_wdata = {WD[2], WD[1], WD[0]};  ifb.m_wdata = {WD[2], WD[1], WD[0]};
    ifa.m_patch_send = PS; ifb.m_patch_send = PS;

    repeat (2) @(posedge CLOCK_25);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      apply(1'b0, vecs[i].req, vecs[i].wr, vecs[i].gnt, vecs[i].own,
            vecs[i].act, vecs[i].write, vecs[i].te, 1'b0, vecs[i].name);
      @(posedge CLOCK_25); #1;
    end

    // Round-robin rotation with forced preemption every 4 cycles on DUT B.
    apply(1'b1, 3'b001, 3'b000, 3'b000, 1, 0, 0, 0, 1'b0, "t4_first_req");
    @(posedge CLOCK_25); #1;
    for (int k = 1; k <= 24; k++) begin
      int         o;
      logic [2:0] g;
      logic       te;
      o  = ((k - 1) / 4) % 3;
      g  = 3'b001 << o;
      te = (k >= 5) && ((k - 1) % 4 == 0);
      apply(1'b1, 3'b111, 3'b000, g, o, 1, 0, te, 1'b0, "t4_rotate");
      @(posedge CLOCK_25); #1;
    end
    ifb.req = '0;

    // Let DUT A drain back to idle before the reset sequence.
    ifa.req = '0; ifa.m_write = '0;
    repeat (8) @(posedge CLOCK_25);
    #1;
    apply(1'b0, 3'b100, 3'b000, 3'b000, 1, 0, 0, 0, 1'b0, "t6_req");
    @(posedge CLOCK_25); #1;
    apply(1'b0, 3'b100, 3'b100, 3'b100, 2, 1, 1, 0, 1'b0, "t6_own_wr");
    @(posedge CLOCK_25); #1;
    apply(1'b0, 3'b100, 3'b110, 3'b000, 1, 0, 0, 0, 1'b1, "t6_async_rst");
    #2 rst = 1'b1;
    @(posedge CLOCK_25); #1;
    apply(1'b0, 3'b100, 3'b110, 3'b000, 1, 0, 0, 0, 1'b1, "t6_in_rst");
    @(posedge CLOCK_25); #1;
    rst = 1'b0;
    apply(1'b0, 3'b000, 3'b010, 3'b000, 1, 0, 1, 0, 1'b0, "t6_post_rst");
    @(posedge CLOCK_25); #1;
    apply(1'b0, 3'b000, 3'b010, 3'b000, 1, 0, 1, 0, 1'b0, "t6_idle");
    @(posedge CLOCK_25); #1;

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
